psum_accumulator_pn: RTL and testbench
======================================

// Module: psum_accumulator_pn
// PURPOSE
//  Parametrised, clocked partial-sum accumulator for the SNN accelerator.
//  - Collects one partial-sum packet from each of NUM_PE processing elements for a timestep.
//  - Adds their sum to a per-neuron membrane potential held in an internal array.
//  - Compares the result against THRESH and emits a membrane-potential packet, plus a spike packet when the neuron fires.
//  - Sits between the PE array and the NoC router; generalises the fixed 3-PE adder to N PEs and N neurons.
// PARAMETERS
//  NUM_PE    3      PEs contributing one partial sum per round (1..8)
//  NUM_NEU   4      neurons with stored potentials (power of 2, <=16)
//  PKT_W     34     packet width
//  DATA_W    8      partial-sum / potential width (unsigned)
//  ADDR_W    4      node address width
//  ADDER_ID  4'b0100  this block's NoC address
//  THRESH    20     firing threshold (DATA_W bits)
//  LEAK      1      leak per round (used only with PSUM_LEAK_EN)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input packet valid
//  in_ready   out  1      block accepts input this cycle
//  in_data    in   PKT_W  [33:30] src PE addr, [29:26] dst, [25:24] type, [11:8] neuron idx, [7:0] partial
//  out_valid  out  1      output packet valid
//  out_ready  in   1      downstream accepts output
//  out_data   out  PKT_W  [33:30] dst, [29:26] ADDER_ID, [25:24] type (01 mem_p, 10 spike), [11:8] neuron, [7:0] payload
//  err_dup    out  1      sticky: duplicate PE packet seen in a round
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - FSM to COLLECT; all potentials, acc, and PE bitmap cleared.
//    - in_ready=0, out_valid=0, out_data=0, err_dup=0.
//    - in_ready rises the first cycle after rst_n deasserts.
//    - Reset mid-round discards all partials and any pending output.
//  - Handshake: a transfer occurs on the rising edge with valid&ready.
//    - out_data and out_valid stay stable until out_ready is sampled high.
//  - PE index = src - 4'b1000. Packets with PE index >= NUM_PE, or dst != ADDER_ID, are accepted and dropped.
//  - FSM:
//    - COLLECT: in_ready=1.
//      - Valid packet with its bitmap bit clear: set the bit; acc += partial, saturating at 2^DATA_W-1.
//      - Bit already set: drop, set err_dup.
//      - The neuron idx of the first packet in the round is latched; later packets' idx is ignored.
//      - When all NUM_PE bits are set -> SUM. The final packet's own acceptance edge counts.
//    - SUM (1 cycle, in_ready=0):
//      - v = sat(pot[idx] + acc).
//      - fire = (v >= THRESH).
//      - pot[idx] = fire ? 0 : v.
//      - -> SEND_MP.
//    - SEND_MP: out_valid=1, type 01, payload = new pot[idx], dst = latched src of last PE.
//      - On accept: -> SEND_SPK if fire, else -> COLLECT.
//    - SEND_SPK: out_valid=1, type 10, payload = {4'b0, idx}.
//      - On accept: -> COLLECT; bitmap and acc cleared.
//  - Latency: last partial accepted at edge N -> mem_p packet valid after edge N+2.
//  - Back-to-back rounds: COLLECT is re-entered on the accepting edge; the next input can be taken the following cycle.
//  - Arithmetic is unsigned with saturation; there is no wrap-around.
//  - err_dup is cleared only by reset.
// CONFIGURATION
//  - PSUM_LEAK_EN defined:
//    - SUM computes v = sat(pot[idx] + acc) then subtracts LEAK, flooring at 0, before the compare.
//    - The leak is applied once per round, to the addressed neuron only.
//  - PSUM_LEAK_EN undefined: no leak; LEAK is ignored.
// TESTING
//  T1 NUM_PE=3, THRESH=20, neuron 0: PE1=10, PE2=5, PE3=1 -> mem_p payload 16; no spike packet.
//  T2 Repeat T1 on neuron 0 -> v=32>=20: mem_p payload 0, then spike packet type 10, payload 0.
//  T3 PE1 sent twice (10, 7) then PE2=5, PE3=1 -> second PE1 dropped, err_dup=1, mem_p payload 16.
//  T4 PEs each send 200 -> acc saturates at 255: mem_p 0, spike emitted; out_ready held low 5 cycles -> out_data stable throughout.
//  T5 rst_n pulsed low after 2 of 3 partials -> all outputs 0 at once; new round 1,1,1 -> mem_p 3.
//  T6 With PSUM_LEAK_EN, LEAK=1: T1 stimulus -> mem_p 15.
//     Without PSUM_LEAK_EN -> mem_p 16.

Source files
------------

// File: rtl/psum_accumulator_pn.sv
// psum_accumulator_pn
//   Partial-sum accumulator for the SNN accelerator. One partial sum is collected
//   from each of NUM_PE processing elements per round. The saturated total is added
//   to the addressed neuron's stored membrane potential and compared with THRESH.
//   A membrane-potential packet is then sent, followed by a spike packet if the
//   neuron fired.
//
//   Optional feature: define PSUM_LEAK_EN to subtract LEAK (floored at 0) from the
//   addressed neuron's potential once per round, before the threshold compare.
//
// Ports
//   clk       in   1      clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   in_valid  in   1      input packet valid
//   in_ready  out  1      block accepts input this cycle
//   in_data   in   PKT_W  [33:30] src, [29:26] dst, [25:24] type, [11:8] neuron, [7:0] partial
//   out_valid out  1      output packet valid
//   out_ready in   1      downstream accepts output
//   out_data  out  PKT_W  [33:30] dst, [29:26] ADDER_ID, [25:24] type, [11:8] neuron, [7:0] payload
//   err_dup   out  1      sticky: duplicate PE packet seen in a round
module psum_accumulator_pn #(
  parameter int unsigned       NUM_PE   = 3,
  parameter int unsigned       NUM_NEU  = 4,
  parameter int unsigned       PKT_W    = 34,
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] ADDER_ID = ADDR_W'(4),
  parameter logic [DATA_W-1:0] THRESH   = DATA_W'(20),
  parameter logic [DATA_W-1:0] LEAK     = DATA_W'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_data,
  output logic             err_dup
);

  // Packet field layout
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned IDX_LSB  = DATA_W;
  localparam int unsigned SRC_LSB  = PKT_W - ADDR_W;
  localparam int unsigned DST_LSB  = PKT_W - 2 * ADDR_W;
  localparam int unsigned TYPE_LSB = DST_LSB - 2;
  localparam int unsigned PAD_W    = TYPE_LSB - IDX_W - DATA_W;
  localparam int unsigned NIDX_W   = (NUM_NEU > 1) ? $clog2(NUM_NEU) : 1;

  // PE addresses start at the address with only the MSB set
  localparam logic [ADDR_W-1:0] PE_BASE  = ADDR_W'(1) << (ADDR_W - 1);
  localparam logic [1:0]        TYPE_MP  = 2'b01;
  localparam logic [1:0]        TYPE_SPK = 2'b10;

`ifdef PSUM_LEAK_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif
  // With the leak disabled the subtraction degenerates to "minus zero"
  localparam logic [DATA_W-1:0] LEAK_AMT = LEAK_ON ? LEAK : '0;

  typedef enum logic [1:0] {
    S_COLLECT  = 2'd0,
    S_SUM      = 2'd1,
    S_SEND_MP  = 2'd2,
    S_SEND_SPK = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [PKT_W-1:0]    out_data_q, out_data_d;
  logic                err_dup_q, err_dup_d;
  logic                fire_q, fire_d;
  logic [NUM_PE-1:0]   bitmap_q, bitmap_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [DATA_W-1:0]   pot_q [NUM_NEU];
  logic                pot_we;
  logic [DATA_W-1:0]   pot_wdata;

  // Input packet decode
  logic [ADDR_W-1:0]   in_src, in_dst, pe_idx;
  logic [IDX_W-1:0]    in_idx;
  logic [DATA_W-1:0]   in_part;
  logic [NUM_PE-1:0]   pe_bit;
  logic                pe_ok, bit_set, in_xfer, out_xfer;
  logic                unused_in;

  assign in_src  = in_data[SRC_LSB +: ADDR_W];
  assign in_dst  = in_data[DST_LSB +: ADDR_W];
  assign in_idx  = in_data[IDX_LSB +: IDX_W];
  assign in_part = in_data[DATA_W-1:0];
  assign unused_in = ^{in_data[TYPE_LSB +: 2], in_data[IDX_LSB + IDX_W +: PAD_W]};

  // Sources below PE_BASE wrap to large indices and are dropped like any other out-of-range PE
  assign pe_idx  = in_src - PE_BASE;
  assign pe_ok   = (32'(pe_idx) < NUM_PE) && (in_dst == ADDER_ID);
  assign pe_bit  = NUM_PE'(1) << pe_idx;
  assign bit_set = |(bitmap_q & pe_bit);

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  // Saturating datapath
  logic [DATA_W:0]     acc_sum, pot_sum;
  logic [DATA_W-1:0]   acc_sat, pot_sat, pot_rd, v_leak;
  logic                fire_c;

  assign acc_sum = {1'b0, acc_q} + {1'b0, in_part};
  assign acc_sat = acc_sum[DATA_W] ? '1 : acc_sum[DATA_W-1:0];
  assign pot_rd  = pot_q[idx_q[NIDX_W-1:0]];
  assign pot_sum = {1'b0, pot_rd} + {1'b0, acc_q};
  assign pot_sat = pot_sum[DATA_W] ? '1 : pot_sum[DATA_W-1:0];
  assign v_leak  = (pot_sat >= LEAK_AMT) ? (pot_sat - LEAK_AMT) : '0;
  assign fire_c  = (v_leak >= THRESH);
  assign pot_wdata = fire_c ? '0 : v_leak;

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_dup_d   = err_dup_q;
    fire_d      = fire_q;
    bitmap_d    = bitmap_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    dst_d       = dst_q;
    pot_we      = 1'b0;

    unique case (state_q)
      S_COLLECT: begin
        if (in_xfer && pe_ok) begin
          if (bit_set) begin
            err_dup_d = 1'b1;
          end else begin
            bitmap_d = bitmap_q | pe_bit;
            acc_d    = acc_sat;
            dst_d    = in_src;
            // Neuron index comes from the first counted packet of the round
            if (bitmap_q == '0) idx_d = in_idx;
            if (&bitmap_d) state_d = S_SUM;
          end
        end
      end
      S_SUM: begin
        pot_we   = 1'b1;
        fire_d   = fire_c;
        bitmap_d = '0;
        acc_d    = '0;
        state_d  = S_SEND_MP;
      end
      S_SEND_MP: begin
        if (out_xfer) begin
          out_valid_d = 1'b0;
          state_d     = fire_q ? S_SEND_SPK : S_COLLECT;
        end else if (!out_valid_q) begin
          // Payload is read after the SUM write, so it is the updated potential
          out_valid_d = 1'b1;
          out_data_d  = {dst_q, ADDER_ID, TYPE_MP, {PAD_W{1'b0}}, idx_q, pot_rd};
        end
      end
      S_SEND_SPK: begin
        if (out_xfer) begin
          out_valid_d = 1'b0;
          state_d     = S_COLLECT;
        end else if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = {dst_q, ADDER_ID, TYPE_SPK, {PAD_W{1'b0}}, idx_q, DATA_W'(idx_q)};
        end
      end
      default: state_d = S_COLLECT;
    endcase

    in_ready_d = (state_d == S_COLLECT);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_COLLECT;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_dup_q   <= 1'b0;
      fire_q      <= 1'b0;
      bitmap_q    <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      dst_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_dup_q   <= err_dup_d;
      fire_q      <= fire_d;
      bitmap_q    <= bitmap_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      dst_q       <= dst_d;
    end
  end

  // Membrane potential store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_NEU); i++) pot_q[i] <= '0;
    end else if (pot_we) begin
      pot_q[idx_q[NIDX_W-1:0]] <= pot_wdata;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err_dup   = err_dup_q;

endmodule

// File: tb/tb_psum_accumulator_pn.sv
// Testbench for psum_accumulator_pn: fixed round table, hand-written corner sequences
// (duplicates, drops, back-pressure, mid-round reset) and randomized rounds checked
// against a round-level arithmetic model.
module tb_psum_accumulator_pn;

  localparam logic [3:0] ID = 4'b0100;
`ifdef PSUM_LEAK_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] out_data;
  logic        err_dup;

  int checks   = 0;
  int failures = 0;
  int mpot[4];
  bit exp_err;

  psum_accumulator_pn dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .err_dup  (err_dup)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] idx;
    logic [7:0] p0, p1, p2;
    int         mp_nl;
    bit         spk_nl;
    int         mp_lk;
    bit         spk_lk;
  } vec_t;

  function automatic logic [33:0] mk_in(input logic [3:0] src, input logic [3:0] dst,
                                        input logic [3:0] idx, input logic [7:0] part);
    return {src, dst, 2'b01, 12'h000, idx, part};
  endfunction

  function automatic logic [33:0] mk_out(input logic [3:0] dst, input logic [1:0] typ,
                                         input logic [3:0] idx, input logic [7:0] pay);
    return {dst, ID, typ, 12'h000, idx, pay};
  endfunction

  function automatic void chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endfunction

  // Round-level reference: saturating add, optional leak, threshold, reset on fire
  function automatic void model_round(input int idx, input int acc, output int mp, output bit spk);
    int v;
    if (acc > 255) acc = 255;
    v = mpot[idx] + acc;
    if (v > 255) v = 255;
    if (LEAK_ON) v = (v >= 1) ? v - 1 : 0;
    spk = (v >= 20);
    mp  = spk ? 0 : v;
    mpot[idx] = mp;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic send(input logic [33:0] pkt);
    int n = 0;
    in_valid = 1'b1;
    in_data  = pkt;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv(input logic [33:0] exp, input int stall, input string name);
    int n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < stall; i++) begin
      chk({name, "_hold_valid"}, 34'(out_valid), 34'(1));
      chk({name, "_hold_data"}, out_data, exp);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk({name, "_valid"}, 34'(out_valid), 34'(1));
    chk({name, "_data"}, out_data, exp);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Entered at the negedge right after the last counted partial was accepted
  task automatic finish_round(input logic [3:0] dst, input logic [3:0] idx, input int mp,
                              input bit spk, input int stall, input string name);
    chk({name, "_lat1_valid"}, 34'(out_valid), 34'(0));
    chk({name, "_lat1_ready"}, 34'(in_ready), 34'(0));
    @(negedge clk);
    chk({name, "_lat2_valid"}, 34'(out_valid), 34'(0));
    @(negedge clk);
    chk({name, "_lat3_valid"}, 34'(out_valid), 34'(1));
    recv(mk_out(dst, 2'b01, idx, 8'(mp)), stall, {name, "_mp"});
    if (spk) begin
      recv(mk_out(dst, 2'b10, idx, {4'b0000, idx}), 0, {name, "_spk"});
    end else begin
      chk({name, "_ready_after"}, 34'(in_ready), 34'(1));
      @(negedge clk);
      chk({name, "_no_spike"}, 34'(out_valid), 34'(0));
    end
    chk({name, "_ready_end"}, 34'(in_ready), 34'(1));
  endtask

  vec_t tbl[8];

  initial begin
    int mp;
    bit spk;

    tbl[0] = '{4'd0, 8'd10,  8'd5,   8'd1,   16, 1'b0, 15, 1'b0};
    tbl[1] = '{4'd0, 8'd10,  8'd5,   8'd1,   0,  1'b1, 0,  1'b1};
    tbl[2] = '{4'd1, 8'd200, 8'd200, 8'd200, 0,  1'b1, 0,  1'b1};
    tbl[3] = '{4'd2, 8'd0,   8'd0,   8'd0,   0,  1'b0, 0,  1'b0};
    tbl[4] = '{4'd2, 8'd19,  8'd0,   8'd0,   19, 1'b0, 18, 1'b0};
    tbl[5] = '{4'd2, 8'd0,   8'd0,   8'd1,   0,  1'b1, 18, 1'b0};
    tbl[6] = '{4'd3, 8'd255, 8'd0,   8'd0,   0,  1'b1, 0,  1'b1};
    tbl[7] = '{4'd0, 8'd1,   8'd1,   8'd1,   3,  1'b0, 2,  1'b0};

    for (int i = 0; i < 4; i++) mpot[i] = 0;
    exp_err   = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_in_ready", 34'(in_ready), 34'(0));
    chk("rst_out_valid", 34'(out_valid), 34'(0));
    chk("rst_out_data", out_data, 34'(0));
    chk("rst_err_dup", 34'(err_dup), 34'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_rise", 34'(in_ready), 34'(1));

    // Fixed rounds from PE sources 8, 9, 10
    for (int i = 0; i < 8; i++) begin
      send(mk_in(4'd8,  ID, tbl[i].idx, tbl[i].p0));
      send(mk_in(4'd9,  ID, tbl[i].idx, tbl[i].p1));
      send(mk_in(4'd10, ID, tbl[i].idx, tbl[i].p2));
      model_round(int'(tbl[i].idx), int'(tbl[i].p0) + int'(tbl[i].p1) + int'(tbl[i].p2), mp, spk);
      finish_round(4'd10, tbl[i].idx,
                   LEAK_ON ? tbl[i].mp_lk : tbl[i].mp_nl,
                   LEAK_ON ? tbl[i].spk_lk : tbl[i].spk_nl,
                   0, $sformatf("tbl%0d", i));
    end
    chk("tbl_err_dup", 34'(err_dup), 34'(0));

    // Duplicate PE plus dropped packets (wrong dst, PE index out of range, src below base)
    send(mk_in(4'd8,  ID,    4'd1, 8'd10));
    send(mk_in(4'd8,  ID,    4'd1, 8'd7));
    send(mk_in(4'd9,  4'd5,  4'd1, 8'd100));
    send(mk_in(4'd12, ID,    4'd1, 8'd100));
    send(mk_in(4'd4,  ID,    4'd1, 8'd100));
    send(mk_in(4'd9,  ID,    4'd3, 8'd5));
    send(mk_in(4'd10, ID,    4'd2, 8'd1));
    model_round(1, 16, mp, spk);
    exp_err = 1'b1;
    finish_round(4'd10, 4'd1, mp, spk, 0, "dup");
    chk("dup_err_dup", 34'(err_dup), 34'(exp_err));

    // Saturating accumulator and back-pressure held for 5 cycles
    send(mk_in(4'd10, ID, 4'd2, 8'd200));
    send(mk_in(4'd8,  ID, 4'd2, 8'd200));
    send(mk_in(4'd9,  ID, 4'd2, 8'd200));
    model_round(2, 600, mp, spk);
    finish_round(4'd9, 4'd2, mp, spk, 5, "sat");
    chk("sat_err_sticky", 34'(err_dup), 34'(1));

    // Reset after two of three partials
    send(mk_in(4'd8, ID, 4'd0, 8'd50));
    send(mk_in(4'd9, ID, 4'd0, 8'd50));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 34'(in_ready), 34'(0));
    chk("mid_rst_out_valid", 34'(out_valid), 34'(0));
    chk("mid_rst_out_data", out_data, 34'(0));
    chk("mid_rst_err_dup", 34'(err_dup), 34'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mpot[i] = 0;
    exp_err = 1'b0;
    @(negedge clk);
    send(mk_in(4'd8,  ID, 4'd0, 8'd1));
    send(mk_in(4'd9,  ID, 4'd0, 8'd1));
    send(mk_in(4'd10, ID, 4'd0, 8'd1));
    model_round(0, 3, mp, spk);
    finish_round(4'd10, 4'd0, mp, spk, 0, "post_rst");

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      int idx;
      int ord[3];
      int acc;
      int part;
      int tmp;
      int j;
      idx = $urandom_range(0, 3);
      ord = '{0, 1, 2};
      for (int k = 2; k > 0; k--) begin
        j = $urandom_range(0, k);
        tmp = ord[k]; ord[k] = ord[j]; ord[j] = tmp;
      end
      acc = 0;
      for (int k = 0; k < 3; k++) begin
        if (k > 0 && $urandom_range(0, 3) == 0) begin
          send(mk_in(4'(8 + ord[0]), ID, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))));
          exp_err = 1'b1;
        end
        if (k > 0 && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 2))
            0: send(mk_in(4'($urandom_range(11, 15)), ID, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))));
            1: send(mk_in(4'($urandom_range(0, 7)), ID, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))));
            default: send(mk_in(4'(8 + ord[k]), 4'($urandom_range(5, 15)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))));
          endcase
        end
        part = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 12);
        send(mk_in(4'(8 + ord[k]), ID, (k == 0) ? 4'(idx) : 4'($urandom_range(0, 15)), 8'(part)));
        acc += part;
      end
      model_round(idx, acc, mp, spk);
      finish_round(4'(8 + ord[2]), 4'(idx), mp, spk, $urandom_range(0, 2), $sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_err_dup", r), 34'(err_dup), 34'(exp_err));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
